dac_sample_pacer: RTL

- Sits between the rvmyth core's 10-bit sample output and the avsddac digital input (D); runs in the PLL-generated CLK domain.
- Buffers core-produced samples in a small FIFO.
- Releases samples to the DAC at a programmable, uniform update rate, so DAC output timing is decoupled from core instruction timing.
- Prefills before starting, holds the last value on starvation, and reports underflow/overflow with sticky flags.

---
 rtl/dac_sample_pacer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/dac_sample_pacer.sv
// Paces core-produced samples out to the DAC at a programmable uniform rate.
// A small FIFO prefills to half depth, then one sample is released per tick; starvation holds dac_d.
module dac_sample_pacer #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 8,
    parameter int DIV_W  = 16
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   enable,
    input  logic [DIV_W-1:0]       rate_div,
    input  logic                   clear_flags,
    output logic [DATA_W-1:0]      dac_d,
    output logic                   dac_strobe,
    output logic [$clog2(DEPTH):0] level,
    output logic                   underflow,
    output logic                   overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] PRIME_LVL = LVL_W'(DEPTH / 2);

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN
    } state_t;

    state_t             state_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [LVL_W-1:0]   level_q;
    logic [DIV_W-1:0]   cnt_q;
    logic [DATA_W-1:0]  dac_d_q;
    logic               strobe_q;
    logic               underflow_q;
    logic               overflow_q;
    logic [DATA_W-1:0]  mem_q [DEPTH];

    logic push;
    logic tick;
    logic pop;
    logic underflow_set;
    logic overflow_set;

    assign in_ready      = (level_q < FULL_LVL);
    assign push          = in_valid && in_ready;
    assign overflow_set  = in_valid && !in_ready;
    // Dropping enable takes priority over a tick that would land on the same edge.
    assign tick          = (state_q == RUN) && enable && (cnt_q >= rate_div);
    assign pop           = tick && (level_q != '0);
    assign underflow_set = tick && (level_q == '0);

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            cnt_q       <= '0;
            dac_d_q     <= '0;
            strobe_q    <= 1'b0;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                dac_d_q  <= mem_q[rd_ptr_q];
                strobe_q <= 1'b1;
            end
            level_q     <= level_q + LVL_W'(push) - LVL_W'(pop);
            underflow_q <= underflow_set | (underflow_q & ~clear_flags);
            overflow_q  <= overflow_set | (overflow_q & ~clear_flags);

            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (enable) begin
                        state_q <= PRIME;
                    end
                end
                PRIME: begin
                    cnt_q <= '0;
                    if (!enable) begin
                        state_q <= IDLE;
                    end else if (level_q >= PRIME_LVL) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (tick) begin
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign dac_d      = dac_d_q;
    assign dac_strobe = strobe_q;
    assign level      = level_q;
    assign underflow  = underflow_q;
    assign overflow   = overflow_q;

endmodule
